// File: rtl/lsu_controller_if.sv
// Signal bundle between the EX stage, the data memory and writeback for lsu_controller.
// The controller is the bus master; the slave view belongs to the surrounding pipeline/memory.
interface lsu_controller_if;
  logic        ex_valid;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_mem_read;
  logic [3:0]  ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_valid;
  logic [1:0]  err_code;

  modport master (
    input  ex_valid, ex_addr, ex_wdata, ex_mem_read, ex_mem_write, ex_funct3, ex_rd,
    input  dmem_ack, dmem_rdata,
    output stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output wb_valid, wb_rd, wb_data, err_valid, err_code
  );

  modport slave (
    output ex_valid, ex_addr, ex_wdata, ex_mem_read, ex_mem_write, ex_funct3, ex_rd,
    output dmem_ack, dmem_rdata,
    input  stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  wb_valid, wb_rd, wb_data, err_valid, err_code
  );
endinterface

// File: rtl/lsu_controller.sv
// Load/store sequencer: issues one req/ack data-memory transaction per EX memory op,
// lane-aligns stores, extends loads, stalls the pipe meanwhile and flags bad accesses.
module lsu_controller #(
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst_n,
  lsu_controller_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] tmo_cnt_r;
  logic [1:0]    off_r;
  logic [2:0]    funct3_r;
  logic [4:0]    rd_r;
  logic          dmem_req_r, dmem_we_r, wb_valid_r, err_valid_r;
  logic [31:0]   dmem_addr_r, dmem_wdata_r, wb_data_r;
  logic [3:0]    dmem_be_r;
  logic [4:0]    wb_rd_r;
  logic [1:0]    err_code_r;

  logic          start_s, both_s, misal_s, tmo_hit_s;
  logic [3:0]    mask_s;
  logic [1:0]    err_code_nxt_s;
  logic [31:0]   load_shift_s;

  function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      3'b000:  extend_load = {{24{d[7]}}, d[7:0]};
      3'b001:  extend_load = {{16{d[15]}}, d[15:0]};
      3'b100:  extend_load = {24'h000000, d[7:0]};
      3'b101:  extend_load = {16'h0000, d[15:0]};
      default: extend_load = d;
    endcase
  endfunction

  assign mask_s       = bus.ex_mem_read | bus.ex_mem_write;
  assign start_s      = bus.ex_valid & (|mask_s);
  assign both_s       = (|bus.ex_mem_read) & (|bus.ex_mem_write);
  assign misal_s      = ((mask_s == 4'b1111) & (bus.ex_addr[1:0] != 2'b00)) |
                        ((mask_s == 4'b0011) & bus.ex_addr[0]);
  // Counter holds the number of REQ cycles already spent without ack.
  assign tmo_hit_s    = (tmo_cnt_r == CW'(TIMEOUT - 1));
  assign load_shift_s = bus.dmem_rdata >> {off_r, 3'b000};

  assign bus.stall      = ((state_r == IDLE) & start_s) | (state_r == REQ);
  assign bus.dmem_req   = dmem_req_r;
  assign bus.dmem_we    = dmem_we_r;
  assign bus.dmem_addr  = dmem_addr_r;
  assign bus.dmem_be    = dmem_be_r;
  assign bus.dmem_wdata = dmem_wdata_r;
  assign bus.wb_valid   = wb_valid_r;
  assign bus.wb_rd      = wb_rd_r;
  assign bus.wb_data    = wb_data_r;
  assign bus.err_valid  = err_valid_r;
  assign bus.err_code   = err_code_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and the error code to report on entry to ERR; ack beats timeout.
  always_comb begin
    state_nxt_s    = state_r;
    err_code_nxt_s = 2'b00;
    case (state_r)
      IDLE: begin
        if (start_s && both_s) begin
          state_nxt_s    = ERR;
          err_code_nxt_s = 2'b11;
        end else if (start_s && misal_s) begin
          state_nxt_s    = ERR;
          err_code_nxt_s = 2'b01;
        end else if (start_s) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (bus.dmem_ack) begin
          state_nxt_s = DONE;
        end else if (tmo_hit_s) begin
          state_nxt_s    = ERR;
          err_code_nxt_s = 2'b10;
        end else begin
          state_nxt_s = REQ;
        end
      end
      DONE:    state_nxt_s = IDLE;
      ERR:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Registered bus, writeback and error outputs plus the latched request context.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_r    <= {CW{1'b0}};
      off_r        <= 2'b00;
      funct3_r     <= 3'b000;
      rd_r         <= 5'd0;
      dmem_req_r   <= 1'b0;
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= 32'h0000_0000;
      dmem_be_r    <= 4'b0000;
      dmem_wdata_r <= 32'h0000_0000;
      wb_valid_r   <= 1'b0;
      wb_rd_r      <= 5'd0;
      wb_data_r    <= 32'h0000_0000;
      err_valid_r  <= 1'b0;
      err_code_r   <= 2'b00;
    end else begin
      dmem_req_r  <= (state_nxt_s == REQ);
      err_valid_r <= (state_nxt_s == ERR);
      wb_valid_r  <= 1'b0;
      tmo_cnt_r   <= (state_r == REQ) ? tmo_cnt_r + CW'(1) : {CW{1'b0}};
      if (state_nxt_s == ERR) begin
        err_code_r <= err_code_nxt_s;
      end
      if ((state_r == IDLE) && (state_nxt_s == REQ)) begin
        dmem_we_r    <= |bus.ex_mem_write;
        dmem_addr_r  <= {bus.ex_addr[31:2], 2'b00};
        dmem_be_r    <= mask_s << bus.ex_addr[1:0];
        dmem_wdata_r <= bus.ex_wdata << {bus.ex_addr[1:0], 3'b000};
        off_r        <= bus.ex_addr[1:0];
        funct3_r     <= bus.ex_funct3;
        rd_r         <= bus.ex_rd;
      end
      if ((state_r == REQ) && bus.dmem_ack && !dmem_we_r) begin
        wb_valid_r <= 1'b1;
        wb_rd_r    <= rd_r;
        wb_data_r  <= extend_load(load_shift_s, funct3_r);
      end
    end
  end
endmodule
